// File: rtl/aespim_pkg.sv
// Shared definitions for the AES PIM accelerator: op-code encodings,
// command sequencer state, and the packed op word sent to the accelerator.
package aespim_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ENCI = 3'd2;
  localparam logic [2:0] OP_ENCM = 3'd3;
  localparam logic [2:0] OP_ENCF = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_STORE,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [2:0] sr;
    logic [2:0] op;
  } acc_op_t;

endpackage

// File: rtl/aespim_round_seq.sv
// Block-encrypt command sequencer: walks LD/ENCI/ENCM/ENCF/ST word ops over
// the memory port, one accelerator start per granted memory access.
module aespim_round_seq
  import aespim_pkg::*;
#(
  parameter int NR = 10,
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_src_i,
  input  logic [AW-1:0] cmd_key_i,
  input  logic [AW-1:0] cmd_dst_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  output logic          acc_start_o,
  output logic [5:0]    acc_op_o,
  output logic          busy_o,
  output logic          done_o
);

  // Handshake: a command transfers on the clock edge where cmd_valid_i and
  // cmd_ready_o are both high; a memory word op completes (and the matching
  // accelerator start fires) on the edge where mem_req_o and mem_gnt_i are high.

  seq_state_e    state_q, state_d;
  logic [1:0]    w_q, w_d;
  logic [3:0]    r_q, r_d;
  logic [AW-1:0] src_q, src_d, key_q, key_d, dst_q, dst_d;
  logic [AW-1:0] base, offs;
  acc_op_t       op_s;
  logic          req, fire, last;

  assign req  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign fire = req & mem_gnt_i;
  assign last = fire & (w_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      r_q     <= '0;
      src_q   <= '0;
      key_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      r_q     <= r_d;
      src_q   <= src_d;
      key_q   <= key_d;
      dst_q   <= dst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    r_d         = r_q;
    src_d       = src_q;
    key_d       = key_q;
    dst_d       = dst_q;
    base        = '0;
    offs        = '0;
    op_s        = '0;
    mem_we_o    = 1'b0;
    cmd_ready_o = 1'b0;
    done_o      = 1'b0;

    if (fire) w_d = w_q + 2'd1;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          src_d   = cmd_src_i;
          key_d   = cmd_key_i;
          dst_d   = cmd_dst_i;
          w_d     = '0;
          r_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        base    = src_q;
        offs    = AW'(w_q);
        op_s.op = OP_LD;
        if (last) state_d = S_INIT;
      end
      S_INIT: begin
        base    = key_q;
        offs    = AW'(w_q);
        op_s.sr = {1'b0, w_q};
        op_s.op = OP_ENCI;
        if (last) begin
          r_d     = 4'd1;
          state_d = (NR == 1) ? S_FINAL : S_ROUND;
        end
      end
      S_ROUND: begin
        // round r's key words start at key + 4*r
        base    = key_q;
        offs    = AW'({r_q, w_q});
        op_s.sr = {1'b0, w_q};
        op_s.op = OP_ENCM;
        if (last) begin
          r_d = r_q + 4'd1;
          if (r_q == 4'(NR - 1)) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        base    = key_q;
        offs    = AW'(4 * NR) + AW'(w_q);
        op_s.sr = {1'b0, w_q};
        op_s.op = OP_ENCF;
        if (last) state_d = S_STORE;
      end
      S_STORE: begin
        base     = dst_q;
        offs     = AW'(w_q);
        op_s.op  = OP_ST;
        mem_we_o = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_o   = req;
  assign mem_addr_o  = base + offs;
  assign acc_start_o = fire;
  assign acc_op_o    = op_s;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aespim_round_seq.sv
// Bench for aespim_round_seq: behavioural memory + AES accelerator model,
// expected op trace built from the sequencing rules, FIPS-197 vector.
module tb_aespim_round_seq;
  import aespim_pkg::*;

  localparam int TW = 23;  // {we, sr[2:0], op[2:0], addr[15:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
  logic [15:0] cmd_src = '0, cmd_key = '0, cmd_dst = '0;
  logic        gnt = 1'b0;

  logic        ready0, req0, we0, start0, busy0, done0;
  logic [15:0] addr0;
  logic [5:0]  op0;
  logic        ready1, req1, we1, start1, busy1, done1;
  logic [15:0] addr1;
  logic [5:0]  op1;

  always #5 clk = ~clk;

  aespim_round_seq #(.NR(10), .AW(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid0), .cmd_ready_o(ready0),
    .cmd_src_i(cmd_src), .cmd_key_i(cmd_key), .cmd_dst_i(cmd_dst),
    .mem_req_o(req0), .mem_we_o(we0), .mem_addr_o(addr0), .mem_gnt_i(gnt),
    .acc_start_o(start0), .acc_op_o(op0), .busy_o(busy0), .done_o(done0)
  );

  aespim_round_seq #(.NR(1), .AW(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid1), .cmd_ready_o(ready1),
    .cmd_src_i(cmd_src), .cmd_key_i(cmd_key), .cmd_dst_i(cmd_dst),
    .mem_req_o(req1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_gnt_i(gnt),
    .acc_start_o(start1), .acc_op_o(op1), .busy_o(busy1), .done_o(done1)
  );

  bit          use1 = 1'b0;
  logic        m_ready, m_req, m_we, m_start, m_busy, m_done;
  logic [15:0] m_addr;
  logic [5:0]  m_op;
  logic [27:0] outs0, outs1;

  assign m_ready = use1 ? ready1 : ready0;
  assign m_req   = use1 ? req1   : req0;
  assign m_we    = use1 ? we1    : we0;
  assign m_start = use1 ? start1 : start0;
  assign m_busy  = use1 ? busy1  : busy0;
  assign m_done  = use1 ? done1  : done0;
  assign m_addr  = use1 ? addr1  : addr0;
  assign m_op    = use1 ? op1    : op0;
  assign outs0 = {ready0, req0, we0, addr0, start0, op0, busy0, done0};
  assign outs1 = {ready1, req1, we1, addr1, start1, op1, busy1, done1};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  logic [TW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  logic [31:0] mem [0:65535];
  logic [31:0] ks [44];
  logic [31:0] st [4];
  logic [31:0] rk [4];
  int          acc_k = 0;
  logic [31:0] pt_v [4] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
  logic [31:0] key_v[4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
  logic [31:0] ct_v [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  task automatic expand_key();
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) ks[i] = key_v[i];
    for (int i = 4; i < 44; i++) begin
      t = ks[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      ks[i] = ks[i-4] ^ t;
    end
  endtask

  task automatic aes_round(input bit is_last);
    logic [7:0] a [4][4];
    logic [7:0] b [4];
    logic [7:0] n [4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) a[c][r] = sbox(8'(st[c] >> (24 - 8 * r)));
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) b[r] = a[(c + r) % 4][r];
      if (is_last) n = b;
      else begin
        n[0] = gmul(b[0], 8'd2) ^ gmul(b[1], 8'd3) ^ b[2] ^ b[3];
        n[1] = b[0] ^ gmul(b[1], 8'd2) ^ gmul(b[2], 8'd3) ^ b[3];
        n[2] = b[0] ^ b[1] ^ gmul(b[2], 8'd2) ^ gmul(b[3], 8'd3);
        n[3] = gmul(b[0], 8'd3) ^ b[1] ^ b[2] ^ gmul(b[3], 8'd2);
      end
      st[c] = {n[0], n[1], n[2], n[3]} ^ rk[c];
    end
  endtask

  // Accelerator stand-in: groups of four same-op starts, data via mem[]
  task automatic accel_step(input logic [2:0] op, input logic [15:0] addr);
    case (op)
      OP_LD:                    st[acc_k] = mem[addr];
      OP_ENCI, OP_ENCM, OP_ENCF: rk[acc_k] = mem[addr];
      OP_ST:                    mem[addr] = st[acc_k];
      default: ;
    endcase
    if (acc_k == 3) begin
      if (op == OP_ENCI) for (int c = 0; c < 4; c++) st[c] = st[c] ^ rk[c];
      if (op == OP_ENCM) aes_round(1'b0);
      if (op == OP_ENCF) aes_round(1'b1);
    end
    acc_k = (acc_k + 1) % 4;
  endtask

  // Expected per-start trace from the op/address rules
  task automatic push_block(input int nr, input logic [15:0] src, key, dst);
    for (int w = 0; w < 4; w++) exp_q.push_back({1'b0, 3'd0, OP_LD, 16'(src + w)});
    for (int w = 0; w < 4; w++) exp_q.push_back({1'b0, 3'(w), OP_ENCI, 16'(key + w)});
    for (int r = 1; r < nr; r++)
      for (int w = 0; w < 4; w++) exp_q.push_back({1'b0, 3'(w), OP_ENCM, 16'(key + 4 * r + w)});
    for (int w = 0; w < 4; w++) exp_q.push_back({1'b0, 3'(w), OP_ENCF, 16'(key + 4 * nr + w)});
    for (int w = 0; w < 4; w++) exp_q.push_back({1'b1, 3'd0, OP_ST, 16'(dst + w)});
  endtask

  // ---------------- monitor ----------------
  logic          prev_wait = 1'b0;
  logic [22:0]   prev_ob;
  logic [TW-1:0] e;

  always @(negedge clk) begin
    if (!rst_n) prev_wait = 1'b0;
    else begin
      if (prev_wait) check_eq("op_hold", {m_we, m_op, m_addr}, prev_ob);
      prev_wait = m_req & ~gnt;
      prev_ob   = {m_we, m_op, m_addr};
      if (m_start) begin
        n_starts++;
        check_eq("start_gnt", gnt, 1'b1);
        if (exp_q.size() == 0) check_eq("trace_extra", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("trace", {m_we, m_op, m_addr}, e);
        end
        accel_step(m_op[2:0], m_addr);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_valid(input bit sel, input logic v);
    if (sel) cmd_valid1 = v;
    else     cmd_valid0 = v;
  endtask

  task automatic load_vec(input logic [15:0] src, key, dst);
    for (int i = 0; i < 4; i++)  mem[16'(src + i)] = pt_v[i];
    for (int i = 0; i < 44; i++) mem[16'(key + i)] = ks[i];
    for (int i = 0; i < 4; i++)  mem[16'(dst + i)] = 32'h0;
  endtask

  task automatic run_block(input bit sel, input int nr, input logic [15:0] src, key, dst,
                           input int stall_pct, input bit noise, input int abort_at);
    int n = 0;
    bit seen = 1'b0;
    use1 = sel;
    n_starts = 0;
    acc_k = 0;
    load_vec(src, key, dst);
    push_block(nr, src, key, dst);
    @(negedge clk);
    check_eq("ready_idle", {m_ready, m_busy}, 2'b10);
    cmd_src = src; cmd_key = key; cmd_dst = dst;
    drive_valid(sel, 1'b1);
    @(posedge clk); #1;
    drive_valid(sel, 1'b0);
    while (!seen && n < 3000) begin
      n++;
      gnt = ($urandom_range(0, 99) >= stall_pct);
      if (noise && $urandom_range(0, 2) == 0) begin
        cmd_src = 16'($urandom); cmd_key = 16'($urandom); cmd_dst = 16'($urandom);
        drive_valid(sel, 1'b1);
      end else drive_valid(sel, 1'b0);
      @(negedge clk);
      if (m_done) seen = 1'b1;
      else check_eq("busy_rdy", {m_busy, m_ready}, 2'b10);
      if (n == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq("rst_mid_outs", sel ? outs1 : outs0, {1'b1, 27'b0});
        check_eq("starts_pre_rst", n_starts, abort_at);
        repeat (2) begin
          @(negedge clk);
          check_eq("no_start_rst", m_start, 1'b0);
        end
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    drive_valid(sel, 1'b0);
    check_eq("done_seen", seen, 1'b1);
    check_eq("n_starts", n_starts, 4 * (nr + 3));
    if (stall_pct == 0) check_eq("latency", n, 4 * (nr + 3) + 1);
    check_eq("trace_left", exp_q.size(), 0);
    if (nr == 10)
      for (int i = 0; i < 4; i++) check_eq("ct_word", mem[16'(dst + i)], ct_v[i]);
    @(negedge clk);
    check_eq("back_idle", {m_ready, m_busy, m_done, m_req}, 4'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] s;
    expand_key();
    check_eq("ks_last", ks[43], 32'hb6630ca6);
    repeat (2) @(negedge clk);
    check_eq("rst_outs0", outs0, {1'b1, 27'b0});
    check_eq("rst_outs1", outs1, {1'b1, 27'b0});
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst0", outs0, {1'b1, 27'b0});
      check_eq("post_rst1", outs1, {1'b1, 27'b0});
    end

    // FIPS-197 vector, grant tied high
    run_block(1'b0, 10, 16'h0100, 16'h0200, 16'h0300, 0, 1'b0, 0);
    // same vector, ~50% grant stalls, random placement
    for (int k = 0; k < 2; k++) begin
      s = 16'($urandom);
      run_block(1'b0, 10, s, 16'(s + 16), 16'(s + 80), 50, 1'b0, 0);
    end
    // command noise while busy
    run_block(1'b0, 10, 16'h1000, 16'h2000, 16'h3000, 0, 1'b1, 0);
    // reset in ROUND r=5 w=2, then a full recovery block
    run_block(1'b0, 10, 16'h4000, 16'h4010, 16'h4080, 0, 1'b0, 27);
    s = 16'($urandom);
    run_block(1'b0, 10, s, 16'(s + 16), 16'(s + 80), 30, 1'b1, 0);
    // NR=1 build with wrapping key addresses
    run_block(1'b1, 1, 16'h0500, 16'hfff0, 16'h0600, 0, 1'b0, 0);
    run_block(1'b1, 1, 16'h0700, 16'hfff0, 16'h0800, 50, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
